// File: rtl/sram_fabric_bridge_if.sv
// Fabric-side request/response channel of the SRAM bridge.
// The master modport is the fabric logic that issues requests and consumes
// responses; the slave modport is the bridge itself.
interface sram_fabric_bridge_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  // Request channel
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_bmask;

  // Response channel
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_fabric_bridge.sv
// Bridge between fabric logic and a 1-port SRAM macro.
// One request at a time: it is captured in IDLE, the macro is driven for a
// single ACCESS cycle from registered outputs, reads wait READ_LATENCY cycles
// for A_DOUT and the result is held in RESP until the consumer accepts it.
// Addresses at or above DEPTH never enable the macro; such reads return 0
// with rsp_err set.
module sram_fabric_bridge #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  UserCLK,
  input  logic                  Reset,
  sram_fabric_bridge_if.slave   bus,
  output logic                  A_MEN,
  output logic                  A_WEN,
  output logic                  A_REN,
  output logic [ADDR_WIDTH-1:0] A_ADDR,
  output logic [DATA_WIDTH-1:0] A_DIN,
  output logic [DATA_WIDTH-1:0] A_BM,
  input  logic [DATA_WIDTH-1:0] A_DOUT
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int CNT_W = 2;
  localparam int AW1   = ADDR_WIDTH + 1;

  // One extra bit so DEPTH == 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = AW1'(DEPTH);
  localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic                  oor_q, oor_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  men_q, men_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] bm_q, bm_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic [DATA_WIDTH-1:0] bm_expand;
  logic                  req_in_range;

  // Widen each byte-enable bit to a full byte of macro bit mask.
  always_comb begin
    bm_expand = '0;
    for (int i = 0; i < BYTES; i++) begin
      bm_expand[i*8 +: 8] = {8{bus.req_bmask[i]}};
    end
  end

  assign req_in_range = ({1'b0, bus.req_addr} < DEPTH_LIM);

  // Next-state and next-output decode for the access sequencer.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that left one
    // unassigned would infer a latch.
    state_d     = state_q;
    we_d        = we_q;
    oor_d       = oor_q;
    cnt_d       = cnt_q;
    men_d       = 1'b0;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    bm_d        = bm_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        // req_ready is 1 in IDLE, so req_valid alone completes the handshake.
        // Macro controls are set here so they are already registered in ACCESS.
        if (bus.req_valid) begin
          state_d = ST_ACCESS;
          we_d    = bus.req_we;
          oor_d   = !req_in_range;
          addr_d  = bus.req_addr;
          din_d   = bus.req_wdata;
          bm_d    = bm_expand;
          men_d   = req_in_range;
          wen_d   = req_in_range & bus.req_we;
          ren_d   = req_in_range & ~bus.req_we;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = oor_q ? '0 : A_DOUT;
          rsp_err_d   = oor_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; synchronous reset returns to IDLE with all outputs low.
  always_ff @(posedge UserCLK) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // independent of statement order.
    if (Reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      cnt_q       <= '0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      bm_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      oor_q       <= oor_d;
      cnt_q       <= cnt_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign A_MEN  = men_q;
  assign A_WEN  = wen_q;
  assign A_REN  = ren_q;
  assign A_ADDR = addr_q;
  assign A_DIN  = din_q;
  assign A_BM   = bm_q;

endmodule

// File: doc/sram_fabric_bridge.md
Name: sram_fabric_bridge

Overview:
- Sits in the IHP SRAM tile directly below the north terminal tile, between the fabric-side wires routed through that tile's switch matrix and the IHP 1-port SRAM macro.
- Accepts single read or write requests from fabric logic over a valid/ready handshake.
- Registers every macro control and data signal and sequences the macro access.
- Returns read data over a valid/ready response channel. At most one transaction is in flight at a time.

Parameters:
- ADDR_WIDTH, 10, macro address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- DEPTH, 1024, number of implemented words; must be ≤ 2^ADDR_WIDTH.
- READ_LATENCY, 1, macro clock edges from an enabled read cycle to valid A_DOUT; range 1..4.

Ports:
- UserCLK  in  1  fabric user clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_bmask  in  DATA_WIDTH/8  per-byte write enable.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_err  out  1  read address was ≥ DEPTH.
- A_MEN  out  1  macro enable.
- A_WEN  out  1  macro write enable.
- A_REN  out  1  macro read enable.
- A_ADDR  out  ADDR_WIDTH  macro address.
- A_DIN  out  DATA_WIDTH  macro write data.
- A_BM  out  DATA_WIDTH  macro bit mask.
- A_DOUT  in  DATA_WIDTH  macro read data.

Behaviour:
- Clocking and reset: all state is on UserCLK rising edges. Reset is synchronous and active-high.
  - Reset value of every output is 0, except req_ready, which is 1 because the FSM resets to IDLE.
  - Reset overrides everything, including mid-access and mid-response: the FSM returns to IDLE, rsp_valid drops and the pending response is discarded. A write in progress may or may not have reached the macro.
- Registered outputs: all macro outputs and all rsp_* outputs come from flops. req_ready is decoded from the state register only, with no combinational path from req_valid.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture req_we, req_addr, req_wdata and req_bmask, then go to ACCESS.
- ACCESS (exactly 1 cycle):
  - req_ready = 0.
  - A_ADDR = captured address.
  - A_DIN = captured data.
  - A_BM = each bmask bit replicated 8 times.
  - In-range address (< DEPTH):
    - A_MEN = 1.
    - A_WEN = we.
    - A_REN = !we.
  - Out-of-range address: A_MEN, A_WEN and A_REN stay 0, so the write is dropped or the read is suppressed.
  - Next state: write goes to IDLE; read goes to WAIT with the latency counter loaded to READ_LATENCY-1.
  - Outside ACCESS, A_MEN, A_WEN and A_REN are 0. A_ADDR, A_DIN and A_BM hold their last values.
- WAIT:
  - Lasts READ_LATENCY cycles, with the counter decrementing each cycle.
  - On the last cycle (counter == 0), capture A_DOUT into rsp_rdata and go to RESP.
  - For out-of-range reads, rsp_rdata is captured as 0 and rsp_err = 1. Otherwise rsp_err = 0.
- RESP:
  - rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable while rsp_ready = 0 (no timeout).
  - On rsp_ready, go to IDLE. rsp_valid drops the next cycle, and rsp_rdata keeps its value.
- Latency (request accepted at the edge ending cycle T):
  - Read: macro enabled in T+1, first rsp_valid cycle is T+2+READ_LATENCY.
  - Write: macro written in T+1, req_ready = 1 again in T+2.
  - Throughput: at best one write per 2 cycles; one read per 3+READ_LATENCY cycles with rsp_ready held high.
- Boundaries:
  - req_valid while req_ready = 0 is ignored and not captured; the requester must hold it.
  - rsp_ready without rsp_valid has no effect.
  - An address exactly equal to DEPTH is out of range.
  - bmask = 0 on a write still pulses A_MEN and A_WEN with A_BM = 0.

Test Plan:
- Reset: assert Reset for 2 cycles mid-stream → next cycle all outputs 0, req_ready = 1, no A_MEN pulse.
- Write then read: write addr 0x005, data 0xDEADBEEF, bmask 4'hF; then read 0x005 with rsp_ready = 1 → one-cycle pulse A_MEN = 1, A_WEN = 1, A_BM = 0xFFFFFFFF; rsp_valid in cycle T+3, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Byte mask: write 0x11223344 with bmask 4'b0101 over stored 0xAAAAAAAA (model the macro) → A_BM = 0x00FF00FF, readback 0xAA22AA44.
- Backpressure: read with rsp_ready held low for 5 cycles → rsp_valid and rsp_rdata stable for all 5 cycles, req_ready = 0, a new req_valid is not accepted until 1 cycle after the rsp handshake.
- Out of range: DEPTH = 1000, read addr 1000 → no A_MEN pulse, rsp_rdata = 0, rsp_err = 1; write addr 1023 → no A_MEN pulse, req_ready back in 2 cycles.
- Latency sweep and mid-read reset: READ_LATENCY = 3 → rsp_valid at T+5; asserting Reset during WAIT → IDLE with no rsp_valid ever asserted.
